// File: rtl/pingpong_merge.sv
// Ping-pong merge: buffers two AXI-Stream branches in private FIFOs and drains
// them alternately in fixed-size groups, regenerating tlast per packet.
module pingpong_merge #(
  parameter int DW          = 128,
  parameter int PP_GROUP    = 2,
  parameter int PACKET_SIZE = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        resetn,

  input  logic [DW-1:0]               axis_in1_tdata,
  input  logic                        axis_in1_tvalid,
  output logic                        axis_in1_tready,

  input  logic [DW-1:0]               axis_in2_tdata,
  input  logic                        axis_in2_tvalid,
  output logic                        axis_in2_tready,

  output logic [DW-1:0]               axis_out_tdata,
  output logic                        axis_out_tvalid,
  input  logic                        axis_out_tready,
  output logic                        axis_out_tlast,

  output logic [$clog2(FIFO_DEPTH):0] fifo1_level,
  output logic [$clog2(FIFO_DEPTH):0] fifo2_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [15:0] GROUP_LAST = 16'(PP_GROUP * PACKET_SIZE - 1);
  localparam logic [15:0] PKT_LAST   = 16'(PACKET_SIZE - 1);

  typedef enum logic {
    SRC1 = 1'b0,
    SRC2 = 1'b1
  } path_e;

  // Per-branch views; index 0 is branch 1, index 1 is branch 2.
  logic [1:0][DW-1:0] in_data;
  logic [1:0]         in_valid;
  logic [1:0]         in_ready;
  logic [1:0][DW-1:0] head;
  logic [1:0]         empty;
  logic [1:0][LW-1:0] level;
  logic [1:0]         pop;

  assign in_data  = {axis_in2_tdata, axis_in1_tdata};
  assign in_valid = {axis_in2_tvalid, axis_in1_tvalid};

  assign axis_in1_tready = in_ready[0];
  assign axis_in2_tready = in_ready[1];
  assign fifo1_level     = level[0];
  assign fifo2_level     = level[1];

  // ---------------------------------------------------------------------------
  // Input FIFOs. Level is kept separately from the pointers so full and empty
  // are unambiguous; ready depends on stored level only, so a same-cycle pop
  // never admits a write into a full FIFO.
  // ---------------------------------------------------------------------------
  for (genvar b = 0; b < 2; b++) begin : g_fifo
    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full;
    logic          push;

    assign full        = (level_q == LW'(FIFO_DEPTH));
    assign in_ready[b] = resetn && !full;
    assign push        = in_valid[b] && in_ready[b];
    assign empty[b]    = (level_q == '0);
    assign head[b]     = mem_q[rd_ptr_q];
    assign level[b]    = level_q;

    // NOTE: every always_comb output gets its default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push)   wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop[b]) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop[b]})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; combinational
    // blocks use blocking ones.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        level_q  <= level_d;
      end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // level alone decide which entries are valid.
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data[b];
    end
  end

  // ---------------------------------------------------------------------------
  // Merge FSM: drain one full group from the selected branch, then toggle.
  // ---------------------------------------------------------------------------
  path_e       path_q, path_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic        sel;
  logic        out_fire;

  assign sel             = (path_q == SRC2);
  assign axis_out_tvalid = !empty[sel];
  assign axis_out_tdata  = head[sel];
  assign axis_out_tlast  = (pkt_cnt_q == PKT_LAST);
  assign out_fire        = axis_out_tvalid && axis_out_tready;

  // Only the selected FIFO is ever popped; a starved branch stalls the output.
  assign pop = out_fire ? (sel ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    path_d     = path_q;
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (out_fire) begin
      if (beat_cnt_q == GROUP_LAST) begin
        beat_cnt_d = '0;
        path_d     = (path_q == SRC1) ? SRC2 : SRC1;
      end else begin
        beat_cnt_d = beat_cnt_q + 16'd1;
      end
      if (pkt_cnt_q == PKT_LAST) pkt_cnt_d = '0;
      else                       pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      path_q     <= SRC1;
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      path_q     <= path_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_pingpong_merge.sv
// Self-checking bench for pingpong_merge: directed scenarios plus random traffic,
// checked each cycle against a queue-based model of the group interleave.
module tb_pingpong_merge;

  localparam int DW          = 128;
  localparam int PP_GROUP    = 2;
  localparam int PACKET_SIZE = 2;
  localparam int DEPTH       = 8;
  localparam int GB          = PP_GROUP * PACKET_SIZE;
  localparam int LW          = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] axis_in1_tdata, axis_in2_tdata, axis_out_tdata;
  logic          axis_in1_tvalid, axis_in1_tready;
  logic          axis_in2_tvalid, axis_in2_tready;
  logic          axis_out_tvalid, axis_out_tready, axis_out_tlast;
  logic [LW-1:0] fifo1_level, fifo2_level;

  pingpong_merge #(
    .DW(DW), .PP_GROUP(PP_GROUP), .PACKET_SIZE(PACKET_SIZE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .axis_in1_tdata  (axis_in1_tdata),
    .axis_in1_tvalid (axis_in1_tvalid),
    .axis_in1_tready (axis_in1_tready),
    .axis_in2_tdata  (axis_in2_tdata),
    .axis_in2_tvalid (axis_in2_tvalid),
    .axis_in2_tready (axis_in2_tready),
    .axis_out_tdata  (axis_out_tdata),
    .axis_out_tvalid (axis_out_tvalid),
    .axis_out_tready (axis_out_tready),
    .axis_out_tlast  (axis_out_tlast),
    .fifo1_level     (fifo1_level),
    .fifo2_level     (fifo2_level)
  );

  always #5 clk = ~clk;

  // Reference model: each branch is a queue of accepted beats; out_cnt counts
  // output beats since reset, which fixes the source branch and tlast.
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q2[$];
  int            out_cnt;
  int            n1, n2;
  logic [DW-1:0] cur1, cur2;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  int            checks;
  int            errors;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input bit v1, input bit v2, input bit ordy);
    bit            src, e_v, e_l, r1, r2, fire;
    logic [DW-1:0] e_d;
    axis_in1_tvalid = v1;
    axis_in1_tdata  = v1 ? cur1 : '0;
    axis_in2_tvalid = v2;
    axis_in2_tdata  = v2 ? cur2 : '0;
    axis_out_tready = ordy;
    @(negedge clk);
    r1  = (q1.size() != DEPTH);
    r2  = (q2.size() != DEPTH);
    src = ((out_cnt / GB) % 2) == 1;
    e_v = src ? (q2.size() != 0) : (q1.size() != 0);
    e_l = (out_cnt % PACKET_SIZE) == PACKET_SIZE - 1;
    check("in1_ready", axis_in1_tready, r1);
    check("in2_ready", axis_in2_tready, r2);
    check("level1", fifo1_level, q1.size());
    check("level2", fifo2_level, q2.size());
    check("out_valid", axis_out_tvalid, e_v);
    check("out_last", axis_out_tlast, e_l);
    if (e_v) begin
      e_d = src ? q2[0] : q1[0];
      check("out_data", axis_out_tdata, e_d);
      if (prev_stall) begin
        check("hold_data", axis_out_tdata, prev_data);
        check("hold_last", axis_out_tlast, prev_last);
      end
    end
    prev_stall = e_v && !ordy;
    prev_data  = axis_out_tdata;
    prev_last  = axis_out_tlast;
    fire       = e_v && ordy;
    @(posedge clk);
    if (fire) begin
      if (src) void'(q2.pop_front());
      else     void'(q1.pop_front());
      out_cnt++;
    end
    if (v1 && r1) begin
      q1.push_back(cur1);
      cur1 = cur1 + 1;
      n1++;
    end
    if (v2 && r2) begin
      q2.push_back(cur2);
      cur2 = cur2 + 1;
      n2++;
    end
    #1;
  endtask

  task automatic do_reset(input int cycles);
    resetn          = 1'b0;
    axis_in1_tvalid = 1'b0;
    axis_in2_tvalid = 1'b0;
    axis_out_tready = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      check("rst_in1_ready", axis_in1_tready, 1'b0);
      check("rst_in2_ready", axis_in2_tready, 1'b0);
      @(posedge clk);
    end
    #1;
    resetn = 1'b1;
    q1.delete();
    q2.delete();
    out_cnt    = 0;
    prev_stall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks          = 0;
    errors          = 0;
    resetn          = 1'b0;
    axis_in1_tdata  = '0;
    axis_in2_tdata  = '0;
    axis_in1_tvalid = 1'b0;
    axis_in2_tvalid = 1'b0;
    axis_out_tready = 1'b0;
    cur1            = '0;
    cur2            = '0;
    do_reset(2);

    // Group order: 01..04 then 11..14, tlast every second beat.
    cur1 = 'h01; cur2 = 'h11; n1 = 0; n2 = 0;
    repeat (16) step(n1 < 4, n2 < 4, 1'b1);

    // Starvation: branch 2 fills while branch 1 is idle, output never skips.
    do_reset(1);
    cur1 = 'h01; cur2 = 'h11; n1 = 0; n2 = 0;
    repeat (12) step(1'b0, n2 < 10, 1'b1);
    repeat (30) step(n1 < 4, n2 < 10, 1'b1);

    // Backpressure: out_tready pattern 1,0,0 under continuous input.
    do_reset(1);
    cur1 = 'h100; cur2 = 'h200; n1 = 0; n2 = 0;
    for (int c = 0; c < 60; c++) step(1'b1, 1'b1, (c % 3) == 0);

    // Full boundary on branch 1: fill, one pop, then the blocked write lands.
    do_reset(1);
    cur1 = 'h300; n1 = 0; n2 = 0;
    repeat (8) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Reset mid-group after two branch-1 beats have left.
    do_reset(1);
    cur1 = 'h400; cur2 = 'h500; n1 = 0; n2 = 0;
    repeat (3) step(1'b1, 1'b0, 1'b1);
    do_reset(1);
    n1 = 0; n2 = 0;
    repeat (14) step(n1 < 4, n2 < 4, 1'b1);

    // Wrap-around: 40 random beats per branch with random valid/ready.
    do_reset(1);
    cur1 = {$urandom, $urandom, $urandom, $urandom};
    cur2 = {$urandom, $urandom, $urandom, $urandom};
    n1 = 0; n2 = 0;
    for (int cyc = 0; cyc < 4000 && (n1 < 40 || n2 < 40); cyc++) begin
      step(n1 < 40 && $urandom_range(0, 3) != 0,
           n2 < 40 && $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0);
    end
    check("wrap_accepts", (n1 >= 40 && n2 >= 40), 1'b1);
    repeat (40) step(1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
